// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared encodings for the multi-cycle data-memory responder:
//               access-size codes and the responder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane helper for a little-endian 32-bit
//               word memory. Generates store byte-enables, replicates store
//               data onto all candidate lanes, selects and extends load data,
//               and flags misaligned or reserved-size accesses.
// Ports       : i_addrLow     byte offset within the word (addr[1:0])
//               i_size        access size code
//               i_unsigned    1 = zero-extend loads, 0 = sign-extend
//               i_wdata       raw store data (low bytes used for byte/half)
//               i_rdataWord   full word read from the array
//               o_byteEn      per-lane write enables
//               o_wdataLanes  store data positioned on every possible lane
//               o_loadData    extended load result
//               o_misaligned  alignment violation or reserved size
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  i_addrLow,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdataWord,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdataLanes,
    output logic [31:0] o_loadData,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane k of the word holds byte address offset k.
    always_comb begin
        w_byte = i_rdataWord[7:0];
        case (i_addrLow)
            2'd0:    w_byte = i_rdataWord[7:0];
            2'd1:    w_byte = i_rdataWord[15:8];
            2'd2:    w_byte = i_rdataWord[23:16];
            default: w_byte = i_rdataWord[31:24];
        endcase
    end

    // A legal half always sits on lanes 1:0 or 3:2, so addr[1] picks it.
    assign w_half = i_addrLow[1] ? i_rdataWord[31:16] : i_rdataWord[15:0];

    always_comb begin
        o_byteEn     = 4'b0000;
        o_wdataLanes = i_wdata;
        o_loadData   = 32'h0000_0000;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_byteEn     = 4'b0001 << i_addrLow;
                o_wdataLanes = {4{i_wdata[7:0]}};
                o_loadData   = i_unsigned ? {24'h000000, w_byte}
                                          : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_byteEn     = i_addrLow[1] ? 4'b1100 : 4'b0011;
                o_wdataLanes = {2{i_wdata[15:0]}};
                o_loadData   = i_unsigned ? {16'h0000, w_half}
                                          : {{16{w_half[15]}}, w_half};
                o_misaligned = i_addrLow[0];
            end
            SZ_WORD: begin
                o_byteEn     = 4'b1111;
                o_loadData   = i_rdataWord;
                o_misaligned = |i_addrLow;
            end
            default: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Stalling data-memory responder. Accepts one load/store at a
//               time, inserts WAIT_CYCLES wait states, performs the access on
//               an internal word array and returns extended read data or a
//               store acknowledge as a one-cycle resp_valid pulse.
// Ports       : clk, rst             clock, synchronous active-high reset
//               req_valid/req_ready  request handshake
//               req_write            1 = store, 0 = load
//               req_addr             byte address
//               req_wdata            store data
//               req_size             00 byte, 01 half, 10 word, 11 reserved
//               req_unsigned         zero-extend loads when set
//               resp_valid           one-cycle response pulse
//               resp_rdata           load data (0 for stores and errors)
//               resp_err             misaligned / reserved / out-of-range
//               stall                processor freeze, acceptance to response
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [31:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    logic [3:0]  r_waitCnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;

    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rdWord;
    logic [3:0]         w_byteEn;
    logic [31:0]        w_wdataLanes;
    logic [31:0]        w_loadData;
    logic               w_misaligned;
    logic               w_outOfRange;
    logic               w_err;

    assign w_idx        = r_addr[c_IDX_W+1:2];
    assign w_rdWord     = r_mem[w_idx];
    // Compare the full word index so high address bits cannot alias into the array.
    assign w_outOfRange = (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err        = w_misaligned | w_outOfRange;

    mem_lane_align u_laneAlign (
        .i_addrLow    (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .i_rdataWord  (w_rdWord),
        .o_byteEn     (w_byteEn),
        .o_wdataLanes (w_wdataLanes),
        .o_loadData   (w_loadData),
        .o_misaligned (w_misaligned)
    );

    // Storage is deliberately not reset. A store whose ACCESS edge coincides
    // with rst is dropped, matching the FSM abandoning the request.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ACCESS) && r_write && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byteEn[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdataLanes[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_size     <= SZ_BYTE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
            stall      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                // RESP accepts like IDLE so back-to-back requests lose no cycle.
                IDLE, RESP: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_size     <= req_size;
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ACCESS;
                        end else begin
                            r_state   <= WAIT;
                            r_waitCnt <= c_WAIT_LOAD;
                        end
                    end else begin
                        r_state   <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state <= ACCESS;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_err   <= w_err;
                    resp_rdata <= (w_err || r_write) ? 32'h0000_0000 : w_loadData;
                    stall      <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= RESP;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A WAIT_CYCLES=2
//               instance carries the directed and random traffic; a
//               WAIT_CYCLES=0 instance covers the zero-wait latency. Expected
//               values come from a byte-addressed reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;
    localparam logic [1:0] SZR = 2'b11;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        sel0;

    logic        ready2, valid2, err2, stall2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0, stall0;
    logic [31:0] rdata0;

    logic        obsReady, obsValid, obsErr, obsStall;
    logic [31:0] obsRdata;

    int checks;
    int errors;

    logic [7:0] refMem [0:1023];

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid && !sel0),
        .req_ready    (ready2),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (valid2),
        .resp_rdata   (rdata2),
        .resp_err     (err2),
        .stall        (stall2)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid && sel0),
        .req_ready    (ready0),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (valid0),
        .resp_rdata   (rdata0),
        .resp_err     (err0),
        .stall        (stall0)
    );

    assign obsReady = sel0 ? ready0 : ready2;
    assign obsValid = sel0 ? valid0 : valid2;
    assign obsErr   = sel0 ? err0   : err2;
    assign obsStall = sel0 ? stall0 : stall2;
    assign obsRdata = sel0 ? rdata0 : rdata2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: byte-addressed little-endian memory, access computed
    // from the size in bytes and plain arithmetic.
    task automatic modelAccess(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input bit u,
                               output logic [31:0] expData, output bit expErr);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        expErr  = (sz == SZR) || ((a % n) != 0) || ((a / 4) >= 256);
        expData = 32'h0;
        if (!expErr) begin
            if (wr) begin
                for (int i = 0; i < n; i++) refMem[a + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(refMem[a + i]) << (8 * i));
                if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                expData = v;
            end
        end
    endtask

    // Presents a request at a falling edge and returns just after the accepting edge.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit u);
        int t;
        t = 0;
        while (obsReady !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (obsReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_ready: req_ready=%b, required 1", obsReady);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_wdata = d; req_size = sz; req_unsigned = u;
        @(posedge clk);
    endtask

    // Waits (bounded) for the response; lat counts rising edges from acceptance
    // to the edge that samples resp_valid. Returns at the response's falling edge.
    task automatic waitResp(output logic [31:0] rd, output bit e, output int lat,
                            output bit stallOk);
        int edges;
        edges = 0; lat = -1; rd = 32'h0; e = 1'b0; stallOk = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            if (obsValid === 1'b1) begin
                lat = edges + 1; rd = obsRdata; e = obsErr;
                if (obsStall !== 1'b0 || obsReady !== 1'b1) stallOk = 1'b0;
                break;
            end
            if (obsStall !== 1'b1 || obsReady !== 1'b0) stallOk = 1'b0;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic doTxn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit u,
                         output logic [31:0] rd, output bit e, output int lat, output bit stallOk);
        issue(wr, a, d, sz, u);
        waitResp(rd, e, lat, stallOk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, want 1", ready2); end
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, want 0", valid2); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, want 0", rdata2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, want 0", err2); end
        checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, want 0", stall2); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b, want 1", ready0); end
    endtask

    task automatic test_basic();
        logic [31:0] rd, m; bit e, me, so; int lat;
        doTxn(1, 32'h10, 32'hDEADBEEF, SZW, 0, rd, e, lat, so);
        modelAccess(1, 32'h10, 32'hDEADBEEF, SZW, 0, m, me);
        checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d, want 4", lat); end
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL store_ack: rdata=%h err=%b, want 0/0", rd, e); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL store_stall: stall/ready profile bad=%b, want 1", so); end
        @(negedge clk);
        doTxn(0, 32'h10, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got %h, want deadbeef", rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL load_latency: got %0d, want 4", lat); end
        @(negedge clk);
        // Response registers hold after the pulse.
        checks++; if (valid2 !== 1'b0 || rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL resp_hold: valid=%b rdata=%h, want 0/deadbeef", valid2, rdata2); end
        doTxn(0, 32'h13, 32'h0, SZB, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL load_byte_s: got %h, want ffffffde", rd); end
        doTxn(0, 32'h13, 32'h0, SZB, 1, rd, e, lat, so);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL load_byte_u: got %h, want 000000de", rd); end
        doTxn(0, 32'h10, 32'h0, SZH, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL load_half_s: got %h, want ffffbeef", rd); end
        doTxn(0, 32'h12, 32'h0, SZH, 1, rd, e, lat, so);
        checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL load_half_u: got %h, want 0000dead", rd); end
        doTxn(1, 32'h11, 32'hFFFFFF5A, SZB, 0, rd, e, lat, so);
        modelAccess(1, 32'h11, 32'hFFFFFF5A, SZB, 0, m, me);
        doTxn(0, 32'h10, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL store_byte_merge: got %h, want dead5aef", rd); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [31:0] rd; bit e, so; int lat;
        doTxn(0, 32'h11, 32'h0, SZH, 0, rd, e, lat, so);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_half: err=%b rdata=%h, want 1/0", e, rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL err_latency: got %0d, want 4", lat); end
        doTxn(0, 32'h10, 32'h0, SZR, 0, rd, e, lat, so);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL reserved_size: err=%b rdata=%h, want 1/0", e, rd); end
        doTxn(1, 32'h12, 32'h11223344, SZW, 0, rd, e, lat, so);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_word_store: err=%b, want 1", e); end
        doTxn(0, 32'h400, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL out_of_range: err=%b rdata=%h, want 1/0", e, rd); end
        doTxn(0, 32'h10, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (e !== 1'b0 || rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL after_errors: err=%b rdata=%h, want 0/dead5aef", e, rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd, m; bit e, me, so; int lat; bit seen;
        doTxn(1, 32'h20, 32'hCAFEF00D, SZW, 0, rd, e, lat, so);
        modelAccess(1, 32'h20, 32'hCAFEF00D, SZW, 0, m, me);
        @(negedge clk);
        // Reset during WAIT.
        issue(1, 32'h20, 32'h12345678, SZW, 0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (stall2 !== 1'b0 || ready2 !== 1'b1 || valid2 !== 1'b0) begin errors++; $display("FAIL midreset_state: stall=%b ready=%b valid=%b, want 0/1/0", stall2, ready2, valid2); end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (valid2 === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_resp: resp_valid seen=%b, want 0", seen); end
        doTxn(0, 32'h20, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_mem: got %h, want cafef00d", rd); end
        @(negedge clk);
        // Reset coinciding with the ACCESS edge.
        issue(1, 32'h20, 32'h11111111, SZW, 0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (valid2 !== 1'b0 || ready2 !== 1'b1) begin errors++; $display("FAIL access_reset_state: valid=%b ready=%b, want 0/1", valid2, ready2); end
        doTxn(0, 32'h20, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL access_reset_mem: got %h, want cafef00d", rd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, m; bit e, me, so; int lat;
        doTxn(1, 32'h24, 32'hA5A55A5A, SZW, 0, rd, e, lat, so);
        modelAccess(1, 32'h24, 32'hA5A55A5A, SZW, 0, m, me);
        // Issued at the RESP falling edge: accepted in the RESP cycle.
        doTxn(0, 32'h24, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL b2b_data: got %h, want a5a55a5a", rd); end
        checks++; if (lat !== 4 || so !== 1'b1) begin errors++; $display("FAIL b2b_latency: lat=%0d stallOk=%b, want 4/1", lat, so); end
        @(negedge clk);
        sel0 = 1'b1;
        @(negedge clk);
        doTxn(1, 32'h08, 32'h0BADCAFE, SZW, 0, rd, e, lat, so);
        checks++; if (lat !== 2 || so !== 1'b1) begin errors++; $display("FAIL w0_store_latency: lat=%0d stallOk=%b, want 2/1", lat, so); end
        doTxn(0, 32'h08, 32'h0, SZW, 0, rd, e, lat, so);
        checks++; if (rd !== 32'h0BADCAFE || lat !== 2) begin errors++; $display("FAIL w0_load: rdata=%h lat=%0d, want 0badcafe/2", rd, lat); end
        doTxn(0, 32'h0B, 32'h0, SZB, 1, rd, e, lat, so);
        checks++; if (rd !== 32'h0000000B || lat !== 2) begin errors++; $display("FAIL w0_load_byte: rdata=%h lat=%0d, want 0000000b/2", rd, lat); end
        @(negedge clk);
        sel0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, m, a, d; bit e, me, so, wr, u; int lat; logic [1:0] sz;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            doTxn(1, 32'(4 * w), d, SZW, 0, rd, e, lat, so);
            modelAccess(1, 32'(4 * w), d, SZW, 0, m, me);
            checks++; if (e !== 1'b0 || lat !== 4) begin errors++; $display("FAIL rand_init w%0d: err=%b lat=%0d, want 0/4", w, e, lat); end
        end
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            wr = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            d  = $urandom;
            a  = ($urandom_range(0, 15) == 0) ? 32'(32'h400 + $urandom_range(0, 255))
                                                : 32'($urandom_range(0, 63));
            doTxn(wr, a, d, sz, u, rd, e, lat, so);
            modelAccess(wr, a, d, sz, u, m, me);
            checks++;
            if (rd !== m || e !== me || lat !== 4 || so !== 1'b1) begin
                errors++;
                $display("FAIL rand_op%0d wr=%0d a=%h sz=%0d u=%0d: rdata=%h err=%b lat=%0d stallOk=%b, want %h/%b/4/1",
                         n, wr, a, sz, u, rd, e, lat, so, m, me);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; sel0 = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = SZW; req_unsigned = 1'b0;
        test_reset();
        test_basic();
        test_errors();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
